// File: rtl/mux_scan_sel_pkg.sv
// Shared mode encodings and the one-hot channel-enable helper for mux_scan_sel.
package mux_scan_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Widest enable the helper can build; callers size-cast the result down to N.
  localparam int MAX_CH = 64;

  function automatic logic [MAX_CH-1:0] onehot(input int unsigned idx, input int unsigned n);
    logic [MAX_CH-1:0] oh;
    oh = '0;
    if ((idx < n) && (idx < MAX_CH)) begin
      oh = {{(MAX_CH-1){1'b0}}, 1'b1} << idx;
    end
    return oh;
  endfunction

endpackage

// File: rtl/mux_scan_sel_dwell_counter.sv
// Dwell counter for scan mode: counts 0..DWELL-1 while enabled, TC flags the last count.
module dwell_counter #(
  parameter int DWELL = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic clr_i,
  output logic tc_o
);

  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == LAST);

endmodule

// File: rtl/mux_scan_sel.sv
// Registered N-channel selector: follows SEL in direct mode or rotates channels with a
// fixed dwell in scan mode. OUT, CH_IDX and CH_EN all load from one next-index value.
module mux_scan_sel
  import mux_scan_pkg::*;
#(
  parameter int N     = 7,
  parameter int W     = 5,
  parameter int SW    = (N > 1) ? $clog2(N) : 1,
  parameter int DWELL = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [N*W-1:0]  in_i,
  input  logic [SW-1:0]   sel_i,
  input  logic            mode_i,
  input  logic            hold_i,
  output logic [W-1:0]    out_o,
  output logic [SW-1:0]   ch_idx_o,
  output logic [N-1:0]    ch_en_o,
  output logic            step_o
);

  logic [W-1:0]  chan [N];
  logic [W-1:0]  out_q, out_d;
  logic [SW-1:0] ch_idx_q, idx_n, cur_idx;
  logic [N-1:0]  ch_en_q, ch_en_d;
  logic          step_q, step_d;
  logic          tc;
  logic          cnt_clr, cnt_en;

  for (genvar gi = 0; gi < N; gi++) begin : g_chan
    assign chan[gi] = in_i[gi*W +: W];
  end

  assign cnt_clr = (mode_i == MODE_DIRECT);
  assign cnt_en  = !hold_i;

  dwell_counter #(.DWELL(DWELL)) u_dwell (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (cnt_en),
    .clr_i  (cnt_clr),
    .tc_o   (tc)
  );

  always_comb begin
    // An out-of-range index left over from direct mode restarts the scan at channel 0.
    cur_idx = (32'(ch_idx_q) >= N) ? '0 : ch_idx_q;
    step_d  = (mode_i == MODE_SCAN) && !hold_i && tc;
    if (mode_i == MODE_DIRECT) begin
      idx_n = sel_i;
    end else if (step_d) begin
      idx_n = (32'(cur_idx) == N - 1) ? '0 : cur_idx + SW'(1);
    end else begin
      idx_n = cur_idx;
    end

    out_d = '0;
    for (int k = 0; k < N; k++) begin
      if (32'(idx_n) == k) out_d = chan[k];
    end
    ch_en_d = N'(onehot(32'(idx_n), N));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_q    <= '0;
      ch_idx_q <= '0;
      ch_en_q  <= '0;
      step_q   <= 1'b0;
    end else begin
      out_q    <= out_d;
      ch_idx_q <= idx_n;
      ch_en_q  <= ch_en_d;
      step_q   <= step_d;
    end
  end

  assign out_o    = out_q;
  assign ch_idx_o = ch_idx_q;
  assign ch_en_o  = ch_en_q;
  assign step_o   = step_q;

endmodule

// File: tb/tb_mux_scan_sel.sv
// Scoreboard bench for mux_scan_sel: driver pushes model predictions, monitor pops and compares.
module tb_mux_scan_sel;

  localparam int N     = 7;
  localparam int W     = 5;
  localparam int SW    = 3;
  localparam int DWELL = 4;

  typedef struct {
    logic [W-1:0]  out;
    logic [SW-1:0] idx;
    logic [N-1:0]  en;
    logic          step;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N*W-1:0]  in_d, in_v;
  logic [SW-1:0]   sel_d;
  logic            mode_d, hold_d;
  logic [W-1:0]    out_w;
  logic [SW-1:0]   idx_w;
  logic [N-1:0]    en_w;
  logic            step_w;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  int   m_ch  = 0;
  int   m_age = 0;

  mux_scan_sel #(.N(N), .W(W), .SW(SW), .DWELL(DWELL)) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .in_i     (in_d),
    .sel_i    (sel_d),
    .mode_i   (mode_d),
    .hold_i   (hold_d),
    .out_o    (out_w),
    .ch_idx_o (idx_w),
    .ch_en_o  (en_w),
    .step_o   (step_w)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc %0d: got %0h expected %0h", nm, cyc, got, exp);
    end
  endtask

  // Channel-level behaviour: each channel is shown for DWELL cycles, then the next one.
  task automatic drive(input logic md, input logic [SW-1:0] sl, input logic hd);
    exp_t e;
    int   base;
    @(negedge clk);
    if (!rst_n) begin
      rst_n = 1'b1;
      m_ch  = 0;
      m_age = 0;
    end
    in_d = in_v; mode_d = md; sel_d = sl; hold_d = hd;
    e.step = 1'b0;
    if (!md) begin
      m_ch  = int'(sl);
      m_age = 0;
    end else begin
      base = (m_ch >= N) ? 0 : m_ch;
      m_ch = base;
      if (!hd) begin
        if (m_age == DWELL - 1) begin
          m_ch   = (base + 1) % N;
          m_age  = 0;
          e.step = 1'b1;
        end else begin
          m_age++;
        end
      end
    end
    e.idx = SW'(m_ch);
    e.out = (m_ch < N) ? W'(in_v >> (m_ch * W)) : '0;
    e.en  = (m_ch < N) ? (N'(1) << m_ch) : '0;
    sb_q.push_back(e);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_out"},  64'(out_w),  64'(0));
    chk({tag, "_idx"},  64'(idx_w),  64'(0));
    chk({tag, "_en"},   64'(en_w),   64'(0));
    chk({tag, "_step"}, 64'(step_w), 64'(0));
  endtask

  // Monitor: the DUT presents a new registered result after every edge out of reset.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (rst_n && sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("out",  64'(out_w),  64'(e.out));
        chk("idx",  64'(idx_w),  64'(e.idx));
        chk("en",   64'(en_w),   64'(e.en));
        chk("step", 64'(step_w), 64'(e.step));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic md;
    rst_n  = 1'b0;
    in_v   = '1;
    in_d   = '1;
    sel_d  = '0;
    mode_d = 1'b0;
    hold_d = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk_zero("rst");

    // Reset release in direct mode, SEL=0, all-ones input.
    drive(1'b0, 3'd0, 1'b0);

    // Direct selects over every channel plus the out-of-range value.
    for (int k = 0; k < N; k++) in_v[k*W +: W] = W'(k + 10);
    for (int s = 0; s <= N; s++) drive(1'b0, SW'(s), 1'b0);

    // Scan through a full rotation and past the wrap.
    drive(1'b0, 3'd0, 1'b0);
    for (int i = 0; i < 32; i++) drive(1'b1, 3'd0, 1'b0);

    // Hold on channel 3 while its data changes.
    for (int i = 0; i < 40 && m_ch != 3; i++) drive(1'b1, 3'd0, 1'b0);
    chk("reach_ch3", 64'(m_ch), 64'(3));
    drive(1'b1, 3'd0, 1'b0);
    in_v[3*W +: W] = 5'h03;
    for (int i = 0; i < 10; i++) begin
      if (i == 5) in_v[3*W +: W] = 5'h1A;
      drive(1'b1, 3'd0, 1'b1);
    end
    for (int i = 0; i < 8; i++) drive(1'b1, 3'd0, 1'b0);

    // Direct to scan from channel 5, then back to direct SEL=2.
    drive(1'b0, 3'd5, 1'b0);
    for (int i = 0; i < 6; i++) drive(1'b1, 3'd0, 1'b0);
    drive(1'b0, 3'd2, 1'b0);
    drive(1'b0, 3'd2, 1'b0);

    // Out-of-range direct select followed by scan restarts at channel 0.
    drive(1'b0, 3'd7, 1'b0);
    for (int i = 0; i < 6; i++) drive(1'b1, 3'd0, 1'b0);

    // Asynchronous reset while scanning on channel 4.
    for (int i = 0; i < 40 && m_ch != 4; i++) drive(1'b1, 3'd0, 1'b0);
    chk("reach_ch4", 64'(m_ch), 64'(4));
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk_zero("async_rst");
    for (int i = 0; i < 10; i++) drive(1'b1, 3'd0, 1'b0);

    // Randomized traffic: sticky mode, occasional hold, random data and selects.
    md = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 19) == 0) md = ~md;
      if ($urandom_range(0, 7) == 0) in_v = (N*W)'({$urandom(), $urandom()});
      drive(md, SW'($urandom_range(0, 7)), ($urandom_range(0, 4) == 0));
    end

    for (int i = 0; i < 5 && sb_q.size() != 0; i++) @(posedge clk);
    #2;
    chk("drain", 64'(sb_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
